serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
// PURPOSE
//  Parametrised work-frame receiver. Sits between uart_receiver and the miner core.
//  Assembles PAYLOAD_BYTES bytes from the UART byte strobe into one wide register.
//  Adds over the fixed 52-byte loader: optional header sync byte, optional XOR checksum,
//  error reporting and a good-frame counter.
//  Outputs change only on a validated frame, so the core always sees a consistent payload.
// PARAMETERS
//  PAYLOAD_BYTES   52         payload length in bytes (>=1); first byte received lands in MSBs
//  TIMEOUT_CYCLES  24'h800000 inter-byte idle clocks before a partial frame is discarded (>=2)
//  USE_HEADER      1          1: frame starts with HEADER_BYTE; 0: any byte starts a frame
//  HEADER_BYTE     8'hA5      sync value, used only when USE_HEADER=1
//  USE_CHECKSUM    1          1: payload is followed by XOR-of-payload-bytes check byte
// PORTS
//  clk          in   1                  single clock; all logic on posedge
//  reset_n      in   1                  synchronous, active-low reset
//  byte_valid   in   1                  one-cycle strobe from uart_receiver (tx_new_byte)
//  byte_data    in   8                  received byte, valid with byte_valid
//  payload      out  8*PAYLOAD_BYTES    last good frame; byte 0 at [8*PAYLOAD_BYTES-1 -: 8]
//  rx_done      out  1                  one-cycle strobe; same cycle payload updates
//  rx_err       out  1                  one-cycle strobe on a discarded frame/byte
//  err_code     out  2                  01 timeout, 10 checksum mismatch, 11 bad header; held until next rx_err
//  frame_count  out  16                 good frames since reset, wraps FFFF->0000
//  busy         out  1                  high while a frame is partially received (state != IDLE)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state IDLE, byte_cnt/timer/xor_acc/buffer=0.
//    payload=0, rx_done=0, rx_err=0, err_code=00, frame_count=0.
//    Reset mid-frame drops the partial frame without raising rx_err.
//  - FSM states: IDLE, PAYLOAD, CHECK.
//    IDLE + byte_valid:
//      USE_HEADER=1: byte==HEADER_BYTE -> PAYLOAD; otherwise stay IDLE, rx_err=1, err_code=11.
//      USE_HEADER=0: the byte is payload byte 0 -> PAYLOAD, byte_cnt=1.
//    PAYLOAD + byte_valid: shift buffer left 8, insert the byte, xor_acc^=byte, byte_cnt++.
//      On the PAYLOAD_BYTES-th byte: go to CHECK if USE_CHECKSUM, else commit.
//    CHECK + byte_valid:
//      byte==xor_acc -> commit.
//      mismatch -> IDLE, rx_err=1, err_code=10, payload unchanged.
//  - Commit happens on the same edge that samples the final byte:
//      payload <= {buffer,byte} (or buffer when CHECK), rx_done=1 next cycle only,
//      frame_count++ (wrapping), state -> IDLE, byte_cnt/xor_acc cleared.
//    Latency: rx_done high exactly 1 cycle after the final byte_valid cycle.
//    No dead cycle: a byte_valid on the very next clock is accepted as a new frame start.
//  - Timer: cleared on every byte_valid and in IDLE; increments otherwise.
//    In PAYLOAD/CHECK, timer==TIMEOUT_CYCLES-1 with no byte_valid -> IDLE, rx_err=1, err_code=01.
//    byte_valid in that same cycle wins: byte accepted, no timeout.
//  - rx_done and rx_err never assert in the same cycle. Both are registered outputs.
//  - Width rules: byte_cnt is $clog2(PAYLOAD_BYTES+1) bits; timer is $clog2(TIMEOUT_CYCLES) bits.
//    xor_acc is 8 bits, cleared at frame start.
// STRUCTURE
//  - Shared package/include serial_pkg: err_code localparams ERR_NONE/ERR_TIMEOUT/ERR_CSUM/ERR_HDR.
//    Same package holds FSM state encodings and the default HEADER_BYTE.
//  - One sub-module: serial_idle_timer (count, clear, expire strobe).
//    Reused later by the transmit side.
//  - Everything else (FSM, shift buffer, checksum) stays inline. No UART inside.
//    The top level instantiates uart_receiver and connects its byte strobe.
// TESTING
//  1 Good frame (PAYLOAD_BYTES=4, header A5, bytes 11 22 33 44, csum 44)
//    -> rx_done 1 cycle after csum; payload=32'h11223344; frame_count=1.
//  2 Same frame, checksum 45 -> rx_err, err_code=10, payload stays at previous value, frame_count unchanged.
//  3 Header byte 5A in IDLE -> rx_err, err_code=11.
//    A following valid frame is still received correctly.
//  4 TIMEOUT_CYCLES=16; send A5 11 then silence.
//    -> rx_err exactly 16 cycles after the last byte, err_code=01, busy falls.
//    Next frame starts cleanly.
//  5 Back-to-back frames, byte_valid every cycle, USE_HEADER=0 USE_CHECKSUM=0
//    -> two rx_done pulses, no byte lost.
//  6 reset_n low mid-frame after 2 bytes -> all outputs 0, no rx_err.
//    frame_count=0xFFFF + one good frame -> wraps to 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receive/transmit path:
// error codes, FSM state encoding and the default sync byte.
package serial_pkg;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_HDR     = 2'b11;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/serial_idle_timer.sv
// Idle-clock counter: restarts on clear, raises a one-cycle expire strobe when
// TIMEOUT_CYCLES uninterrupted non-clear clocks have elapsed.
module serial_idle_timer #(
  parameter int TIMEOUT_CYCLES = 24'h800000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  // clear has priority, so an event arriving on the final clock still wins
  assign expire = !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Work-frame receiver: assembles PAYLOAD_BYTES bytes from a byte strobe, with
// optional sync header and XOR check byte; payload only changes on a good frame.
module serial_frame_receiver
  import serial_pkg::*;
#(
  parameter int          PAYLOAD_BYTES  = 52,
  parameter int          TIMEOUT_CYCLES = 24'h800000,
  parameter int          USE_HEADER     = 1,
  parameter logic [7:0]  HEADER_BYTE    = DEFAULT_HEADER_BYTE,
  parameter int          USE_CHECKSUM   = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       rx_done,
  output logic                       rx_err,
  output logic [1:0]                 err_code,
  output logic [15:0]                frame_count,
  output logic                       busy
);

  localparam int W  = 8 * PAYLOAD_BYTES;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_BYTES);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic [W-1:0]  buf_q, buf_d;

  logic          commit, err, take_byte;
  logic [1:0]    err_code_nxt;
  logic [W-1:0]  commit_data, shifted;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    xor_inc;
  logic          timer_clear, timer_expire;

  assign shifted = (buf_q << 8) | W'(byte_data);
  assign cnt_inc = byte_cnt_q + CW'(1);
  assign xor_inc = xor_q ^ byte_data;
  assign busy    = (state_q != ST_IDLE);

  assign timer_clear = byte_valid || (state_q == ST_IDLE);

  serial_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .expire  (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    xor_d        = xor_q;
    buf_d        = buf_q;
    commit       = 1'b0;
    commit_data  = buf_q;
    err          = 1'b0;
    err_code_nxt = err_code;
    take_byte    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          if (USE_HEADER != 0) begin
            if (byte_data == HEADER_BYTE) begin
              state_d = ST_PAYLOAD;
            end else begin
              err          = 1'b1;
              err_code_nxt = ERR_HDR;
            end
          end else begin
            // headerless: this byte is already payload byte 0
            take_byte = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          take_byte = 1'b1;
        end else if (timer_expire) begin
          err          = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (byte_valid) begin
          if (byte_data == xor_q) begin
            commit = 1'b1;
          end else begin
            err          = 1'b1;
            err_code_nxt = ERR_CSUM;
          end
        end else if (timer_expire) begin
          err          = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_byte) begin
      buf_d = shifted;
      if (cnt_inc == LAST_CNT && USE_CHECKSUM == 0) begin
        commit      = 1'b1;
        commit_data = shifted;
      end else begin
        state_d    = (cnt_inc == LAST_CNT) ? ST_CHECK : ST_PAYLOAD;
        byte_cnt_d = cnt_inc;
        xor_d      = xor_inc;
      end
    end

    // every path back to IDLE leaves the accumulators clean for the next frame
    if (commit || err) begin
      state_d    = ST_IDLE;
      byte_cnt_d = '0;
      xor_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      xor_q       <= '0;
      buf_q       <= '0;
      payload     <= '0;
      rx_done     <= 1'b0;
      rx_err      <= 1'b0;
      err_code    <= ERR_NONE;
      frame_count <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      xor_q      <= xor_d;
      buf_q      <= buf_d;
      rx_done    <= commit;
      rx_err     <= err;
      if (err) begin
        err_code <= err_code_nxt;
      end
      if (commit) begin
        payload     <= commit_data;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: three configurations driven by directed and
// random byte streams, every output compared each cycle against a frame-level model.
module tb_serial_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn [3];
  logic        bv [3];
  logic [7:0]  bd [3];
  logic        dn [3];
  logic        er [3];
  logic        by [3];
  logic [1:0]  ec [3];
  logic [15:0] fc [3];
  logic [31:0] pl0;
  logic [23:0] pl1;
  logic [7:0]  pl2;

  // u0: 4-byte payload, header + checksum, timeout 16
  serial_frame_receiver #(.PAYLOAD_BYTES(4), .TIMEOUT_CYCLES(16), .USE_HEADER(1),
                          .HEADER_BYTE(8'hA5), .USE_CHECKSUM(1)) u0 (
    .clk(clk), .reset_n(rn[0]), .byte_valid(bv[0]), .byte_data(bd[0]), .payload(pl0),
    .rx_done(dn[0]), .rx_err(er[0]), .err_code(ec[0]), .frame_count(fc[0]), .busy(by[0]));

  // u1: 3-byte payload, no header, no checksum
  serial_frame_receiver #(.PAYLOAD_BYTES(3), .TIMEOUT_CYCLES(16), .USE_HEADER(0),
                          .HEADER_BYTE(8'hA5), .USE_CHECKSUM(0)) u1 (
    .clk(clk), .reset_n(rn[1]), .byte_valid(bv[1]), .byte_data(bd[1]), .payload(pl1),
    .rx_done(dn[1]), .rx_err(er[1]), .err_code(ec[1]), .frame_count(fc[1]), .busy(by[1]));

  // u2: single-byte frames, used for the frame counter wrap
  serial_frame_receiver #(.PAYLOAD_BYTES(1), .TIMEOUT_CYCLES(8), .USE_HEADER(0),
                          .HEADER_BYTE(8'hA5), .USE_CHECKSUM(0)) u2 (
    .clk(clk), .reset_n(rn[2]), .byte_valid(bv[2]), .byte_data(bd[2]), .payload(pl2),
    .rx_done(dn[2]), .rx_err(er[2]), .err_code(ec[2]), .frame_count(fc[2]), .busy(by[2]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int cfg_pb(int i);
    case (i) 0: return 4; 1: return 3; default: return 1; endcase
  endfunction
  function automatic int cfg_tmo(int i);
    return (i == 2) ? 8 : 16;
  endfunction
  function automatic bit cfg_hdr(int i);
    return (i == 0);
  endfunction
  function automatic bit cfg_cs(int i);
    return (i == 0);
  endfunction

  // Model: a frame is a list of collected payload bytes plus an idle-clock count
  bit          in_fr [3];
  int          mn    [3];
  logic [7:0]  mq    [3][4];
  int          idle  [3];
  logic        e_dn  [3];
  logic        e_er  [3];
  logic [1:0]  e_ec  [3];
  logic [31:0] e_pl  [3];
  logic [15:0] e_fc  [3];

  task automatic model_commit(int i);
    logic [31:0] p = '0;
    for (int k = 0; k < mn[i]; k++) p = (p << 8) | 32'(mq[i][k]);
    e_pl[i] = p;
    e_fc[i] = e_fc[i] + 16'd1;
    e_dn[i] = 1'b1;
    in_fr[i] = 1'b0;
    mn[i] = 0;
  endtask

  task automatic model_err(int i, logic [1:0] c);
    e_er[i] = 1'b1;
    e_ec[i] = c;
    in_fr[i] = 1'b0;
    mn[i] = 0;
  endtask

  task automatic model_add(int i, logic [7:0] b);
    mq[i][mn[i]] = b;
    mn[i]++;
    if (mn[i] == cfg_pb(i) && !cfg_cs(i)) model_commit(i);
  endtask

  function automatic logic [7:0] frame_xor(int i);
    logic [7:0] x = '0;
    for (int k = 0; k < mn[i]; k++) x ^= mq[i][k];
    return x;
  endfunction

  task automatic model_step(int i);
    e_dn[i] = 1'b0;
    e_er[i] = 1'b0;
    if (!rn[i]) begin
      in_fr[i] = 1'b0; mn[i] = 0; idle[i] = 0;
      e_ec[i] = 2'b00; e_pl[i] = '0; e_fc[i] = '0;
    end else if (bv[i]) begin
      idle[i] = 0;
      if (!in_fr[i]) begin
        if (cfg_hdr(i)) begin
          if (bd[i] == 8'hA5) begin in_fr[i] = 1'b1; mn[i] = 0; end
          else model_err(i, 2'b11);
        end else begin
          in_fr[i] = 1'b1; mn[i] = 0;
          model_add(i, bd[i]);
        end
      end else if (mn[i] < cfg_pb(i)) begin
        model_add(i, bd[i]);
      end else if (bd[i] == frame_xor(i)) begin
        model_commit(i);
      end else begin
        model_err(i, 2'b10);
      end
    end else if (in_fr[i]) begin
      idle[i]++;
      if (idle[i] == cfg_tmo(i)) model_err(i, 2'b01);
    end
  endtask

  function automatic logic [31:0] got_pl(int i);
    case (i) 0: return pl0; 1: return {8'h0, pl1}; default: return {24'h0, pl2}; endcase
  endfunction

  string pfx [3] = '{"u0", "u1", "u2"};

  always begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      check({pfx[i], ".rx_done"},     32'(dn[i]), 32'(e_dn[i]));
      check({pfx[i], ".rx_err"},      32'(er[i]), 32'(e_er[i]));
      check({pfx[i], ".err_code"},    32'(ec[i]), 32'(e_ec[i]));
      check({pfx[i], ".frame_count"}, 32'(fc[i]), 32'(e_fc[i]));
      check({pfx[i], ".busy"},        32'(by[i]), 32'(in_fr[i]));
      check({pfx[i], ".payload"},     got_pl(i),  e_pl[i]);
    end
  end

  task automatic tick(int i, logic v, logic [7:0] d);
    @(negedge clk);
    bv[i] = v;
    bd[i] = d;
  endtask

  task automatic send0(logic [7:0] h, logic [31:0] b, logic [7:0] c);
    tick(0, 1'b1, h);
    for (int k = 3; k >= 0; k--) tick(0, 1'b1, b[8*k +: 8]);
    tick(0, 1'b1, c);
    tick(0, 1'b0, 8'h00);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, np;
    logic [7:0] b, x, h;
    for (int i = 0; i < 3; i++) begin rn[i] = 1'b0; bv[i] = 1'b0; bd[i] = 8'h00; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rn[i] = 1'b1;
    @(negedge clk);
    check("reset.payload", pl0, 32'h0);
    check("reset.count", 32'(fc[0]), 32'h0);

    // good frame, then the same frame with a bad check byte
    send0(8'hA5, 32'h11223344, 8'h44);
    check("t1.rx_done", 32'(dn[0]), 32'h1);
    check("t1.payload", pl0, 32'h11223344);
    check("t1.count", 32'(fc[0]), 32'd1);
    send0(8'hA5, 32'h11223344, 8'h45);
    check("t2.rx_err", 32'(er[0]), 32'h1);
    check("t2.err_code", 32'(ec[0]), 32'h2);
    check("t2.payload", pl0, 32'h11223344);
    check("t2.count", 32'(fc[0]), 32'd1);

    // bad header, then recovery
    tick(0, 1'b1, 8'h5A);
    tick(0, 1'b0, 8'h00);
    check("t3.rx_err", 32'(er[0]), 32'h1);
    check("t3.err_code", 32'(ec[0]), 32'h3);
    send0(8'hA5, 32'h01020304, 8'h04);
    check("t3.payload", pl0, 32'h01020304);
    check("t3.count", 32'(fc[0]), 32'd2);
    check("t3.code_held", 32'(ec[0]), 32'h3);

    // timeout: edges counted from the one that sampled the last byte
    tick(0, 1'b1, 8'hA5);
    tick(0, 1'b1, 8'h11);
    lat = -1;
    for (int k = 1; k <= 24; k++) begin
      tick(0, 1'b0, 8'h00);
      if (er[0] && lat < 0) begin
        lat = k - 1;
        check("t4.busy", 32'(by[0]), 32'h0);
        check("t4.err_code", 32'(ec[0]), 32'h1);
      end
    end
    check("t4.latency", 32'(lat), 32'd16);
    send0(8'hA5, 32'h0FF000FF, 8'h00);
    check("t4.payload", pl0, 32'h0FF000FF);
    check("t4.count", 32'(fc[0]), 32'd3);

    // back-to-back headerless frames
    np = 0;
    for (int k = 1; k <= 6; k++) begin
      tick(1, 1'b1, 8'(k));
      if (dn[1]) np++;
    end
    tick(1, 1'b0, 8'h00);
    if (dn[1]) np++;
    check("t5.pulses", 32'(np), 32'd2);
    check("t5.payload", {8'h0, pl1}, 32'h00040506);
    check("t5.count", 32'(fc[1]), 32'd2);

    // reset mid-frame
    tick(0, 1'b1, 8'hA5);
    tick(0, 1'b1, 8'h11);
    tick(0, 1'b1, 8'h22);
    @(negedge clk); rn[0] = 1'b0; bv[0] = 1'b0;
    @(negedge clk); rn[0] = 1'b1;
    check("t6.payload", pl0, 32'h0);
    check("t6.count", 32'(fc[0]), 32'h0);
    check("t6.rx_err", 32'(er[0]), 32'h0);
    check("t6.err_code", 32'(ec[0]), 32'h0);
    check("t6.busy", 32'(by[0]), 32'h0);

    // frame counter wrap on single-byte frames
    for (int k = 0; k < 65535; k++) tick(2, 1'b1, 8'($urandom));
    tick(2, 1'b0, 8'h00);
    check("t6.count_ffff", 32'(fc[2]), 32'h0000FFFF);
    tick(2, 1'b1, 8'h5C);
    tick(2, 1'b0, 8'h00);
    check("t6.count_wrap", 32'(fc[2]), 32'h0);
    check("t6.wrap_payload", {24'h0, pl2}, 32'h5C);

    // random frames on u0: occasional bad header, bad check byte, or long gap
    repeat (80) begin
      repeat ($urandom_range(0, 2)) tick(0, 1'b0, 8'h00);
      h = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hA5;
      tick(0, 1'b1, h);
      x = 8'h00;
      for (int k = 0; k < 5; k++) begin
        if (k < 4) begin b = 8'($urandom); x ^= b; end
        else b = ($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
        tick(0, 1'b1, b);
        repeat (($urandom_range(0, 15) == 0) ? 17 : $urandom_range(0, 1)) tick(0, 1'b0, 8'h00);
      end
    end
    tick(0, 1'b0, 8'h00);

    // random byte stream on u1
    repeat (400) begin
      tick(1, 1'($urandom_range(0, 3) != 0), 8'($urandom));
      if ($urandom_range(0, 49) == 0) repeat (20) tick(1, 1'b0, 8'h00);
    end
    tick(1, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
